// File: rtl/qam_slicer_adaptive.sv
// qam_slicer_adaptive: I/Q hard-decision slicer for square QAM (4/16/64-QAM).
//
// Samples di/dq on bitsync and emits per-axis {sign, Gray(m)} decisions two edges later.
// Thresholds are 2*j*unit. The unit comes either from cfg_unit (fixed mode) or from a
// leaky mean of (|I|+|Q|)/2 (adaptive mode). The averager leaks fast during
// acquisition and slowly during tracking.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bitsync         symbol strobe; di/dq valid when high
//   di, dq          signed I/Q samples (DW bits)
//   adapt_en        1 = adaptive unit, 0 = cfg_unit
//   cfg_unit        unsigned unit for fixed mode
//   restart         reinitialise averager and re-enter acquisition
//   sym_i, sym_q    per-axis decision {sign, gray(m)}
//   out_valid       one-cycle strobe per decided symbol
//   lock            tracking reached, or fixed mode
//   unit_out        unit currently in effect (integer part)
module qam_slicer_adaptive #(
  parameter int unsigned DW        = 27,
  parameter int unsigned K         = 2,
  parameter int unsigned INIT_UNIT = 1500000,
  parameter int unsigned ALPHA_ACQ = 2,
  parameter int unsigned ALPHA_TRK = 6,
  parameter int unsigned WARM_LOG2 = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bitsync,
  input  logic [DW-1:0] di,
  input  logic [DW-1:0] dq,
  input  logic          adapt_en,
  input  logic [DW-2:0] cfg_unit,
  input  logic          restart,
  output logic [K-1:0]  sym_i,
  output logic [K-1:0]  sym_q,
  output logic          out_valid,
  output logic          lock,
  output logic [DW-2:0] unit_out
);

  localparam int unsigned FRAC = 8;
  localparam int unsigned AW   = DW + FRAC;
  localparam int unsigned USH  = K - 1 + FRAC;  // avg (fixed point) -> unit
  localparam int unsigned NLVL = 1 << (K - 1);  // amplitude levels per half-axis

  localparam logic [AW-1:0]        AvgInit  = AW'(INIT_UNIT) << USH;
  localparam logic [AW-1:0]        AvgMax   = {AW{1'b1}};
  localparam logic [WARM_LOG2-1:0] WarmLast = {WARM_LOG2{1'b1}};

  localparam logic [0:0] StAcq   = 1'b0;
  localparam logic [0:0] StTrack = 1'b1;

  typedef logic [DW+2:0] thr_t;

  // |x| with the most negative input saturated to the largest positive magnitude.
  function automatic logic [DW-2:0] sat_abs(input logic [DW-1:0] x);
    logic [DW-1:0] neg;
    logic [DW-2:0] mag;
    neg = -x;
    if (!x[DW-1]) begin
      mag = x[DW-2:0];
    end else if (neg[DW-1]) begin
      mag = {(DW-1){1'b1}};
    end else begin
      mag = neg[DW-2:0];
    end
    return mag;
  endfunction

  // m counts thresholds strictly below |x|, so a tie resolves to the inner level.
  function automatic logic [K-1:0] slice_axis(input logic neg, input logic [DW-2:0] mag,
                                              input logic [DW-2:0] unit);
    logic [K-1:0] m;
    logic [K-1:0] sym;
    thr_t         thr;
    m = '0;
    for (int j = 1; j < int'(NLVL); j++) begin
      thr = thr_t'(unit) * thr_t'(2 * j);
      if (thr < thr_t'(mag)) begin
        m = m + K'(1);
      end
    end
    // m < 2**(K-1), so the top bit of the Gray code is free for the sign.
    sym = m ^ (m >> 1);
    sym[K-1] = neg;
    return sym;
  endfunction

  // Stage 1 registers
  logic          s1_valid_q, s1_si_q, s1_sq_q, s1_held_q;
  logic [DW-2:0] s1_ai_q, s1_aq_q, s1_hunit_q;

  // Stage 2 / output registers
  logic [K-1:0] sym_i_q, sym_q_q;
  logic         out_valid_q;

  // Averager and FSM
  logic [AW-1:0]        avg_q, avg_d, avg_upd, a_fx;
  logic [WARM_LOG2-1:0] cnt_q, cnt_d;
  logic [0:0]           state_q, state_d;
  logic                 lock_q, lock_d;

  logic signed [AW+1:0] diff, step, sum;
  logic [DW-2:0]        unit_adapt, unit_s2;

  assign unit_adapt = (DW-1)'(avg_q >> USH);

  // A symbol captured on a restart edge keeps the pre-restart adaptive unit.
  always_comb begin
    unit_s2 = cfg_unit;
    if (adapt_en) begin
      unit_s2 = s1_held_q ? s1_hunit_q : unit_adapt;
    end
  end

  always_comb begin
    a_fx = ((AW'(s1_ai_q) + AW'(s1_aq_q)) >> 1) << FRAC;
    diff = $signed({2'b00, a_fx}) - $signed({2'b00, avg_q});
    step = (state_q == StTrack) ? (diff >>> ALPHA_TRK) : (diff >>> ALPHA_ACQ);
    sum  = $signed({2'b00, avg_q}) + step;
    if (sum[AW+1]) begin
      avg_upd = '0;
    end else if (sum[AW]) begin
      avg_upd = AvgMax;
    end else begin
      avg_upd = sum[AW-1:0];
    end
  end

  always_comb begin
    avg_d   = avg_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (restart) begin
      avg_d   = AvgInit;
      cnt_d   = '0;
      state_d = StAcq;
    end else if (s1_valid_q && adapt_en) begin
      avg_d = avg_upd;
      if (state_q == StAcq) begin
        if (cnt_q == WarmLast) begin
          state_d = StTrack;
        end else begin
          cnt_d = cnt_q + WARM_LOG2'(1);
        end
      end
    end
    lock_d = (state_d == StTrack) || !adapt_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_si_q     <= 1'b0;
      s1_sq_q     <= 1'b0;
      s1_ai_q     <= '0;
      s1_aq_q     <= '0;
      s1_held_q   <= 1'b0;
      s1_hunit_q  <= '0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= bitsync;
      out_valid_q <= s1_valid_q;
      if (bitsync) begin
        s1_si_q    <= di[DW-1];
        s1_sq_q    <= dq[DW-1];
        s1_ai_q    <= sat_abs(di);
        s1_aq_q    <= sat_abs(dq);
        s1_held_q  <= restart;
        s1_hunit_q <= unit_adapt;
      end
      if (s1_valid_q) begin
        sym_i_q <= slice_axis(s1_si_q, s1_ai_q, unit_s2);
        sym_q_q <= slice_axis(s1_sq_q, s1_aq_q, unit_s2);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_q   <= AvgInit;
      cnt_q   <= '0;
      state_q <= StAcq;
      lock_q  <= 1'b0;
    end else begin
      avg_q   <= avg_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  assign sym_i     = sym_i_q;
  assign sym_q     = sym_q_q;
  assign out_valid = out_valid_q;
  assign lock      = lock_q;
  assign unit_out  = adapt_en ? unit_adapt : cfg_unit;

endmodule
